// File: rtl/pico_stream_pkg.sv
// Shared definitions for the PicoBus stream loopback endpoint.
//   STREAM_W      : stream word width in bits
//   SIG_HI/SIG_MID: constant signature fields placed in output bits [127:64]
//   stream_word_t : one stream word
//   format_word() : assembles {sig_hi, sig_mid, checksum, payload}
package pico_stream_pkg;

  localparam int unsigned STREAM_W = 128;

  localparam logic [31:0] SIG_HI  = 32'h42424242;
  localparam logic [31:0] SIG_MID = 32'hDEADBEEF;

  typedef logic [STREAM_W-1:0] stream_word_t;

  function automatic stream_word_t format_word(input logic [31:0] sig_hi,
                                               input logic [31:0] sig_mid,
                                               input logic [31:0] checksum,
                                               input logic [31:0] payload);
    return {sig_hi, sig_mid, checksum, payload};
  endfunction

endpackage

// File: rtl/pico_fwft_fifo.sv
// First-word-fall-through FIFO with a registered head output.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset (pointers, count and dout clear)
//   push  : write din this edge (ignored when full)
//   din   : write data
//   full  : occupancy == DEPTH (registered count only)
//   pop   : retire the head this edge (ignored when empty)
//   dout  : current head word; holds its last value while empty
//   empty : occupancy == 0
module pico_fwft_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_en, pop_en;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = dout_q;

  always_comb begin
    wptr_d  = wptr_q + {{(AW-1){1'b0}}, push_en};
    rptr_d  = rptr_q + {{(AW-1){1'b0}}, pop_en};
    count_d = count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
    dout_d  = dout_q;
    // The head is registered so it can be reset to zero. Its next value is the
    // word at the next read pointer; if that slot is being written on this very
    // edge (empty FIFO, or draining the last word while pushing) the incoming
    // word is forwarded.
    if (count_d != '0) begin
      if (push_en && (wptr_q == rptr_d)) begin
        dout_d = din;
      end else begin
        dout_d = mem[rptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is not reset; stale contents are never visible because the head
  // register is only loaded from slots that hold live data.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/pico_stream_loopback.sv
// 128-bit stream loopback endpoint (PicoBus host stream ID 1).
// Each accepted host word is tagged with a signature and a running 32-bit
// checksum, queued, and returned in order on the read stream.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   s_in_valid  : host write-stream word valid
//   s_in_rdy    : endpoint can accept a word (FIFO not full, not in reset)
//   s_in_data   : host write-stream word; only bits [31:0] are kept
//   s_out_valid : output word available (FIFO not empty)
//   s_out_rdy   : host consumes the output word
//   s_out_data  : {SIG_HI, SIG_MID, checksum, payload}
module pico_stream_loopback #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] SIG_HI  = pico_stream_pkg::SIG_HI,
  parameter logic [31:0] SIG_MID = pico_stream_pkg::SIG_MID
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_in_valid,
  output logic         s_in_rdy,
  input  logic [127:0] s_in_data,
  output logic         s_out_valid,
  input  logic         s_out_rdy,
  output logic [127:0] s_out_data
);

  import pico_stream_pkg::*;

  logic [31:0]  sum_q, sum_d;
  logic         accept;
  logic         fifo_full, fifo_empty;
  stream_word_t push_word;
  stream_word_t head_word;
  logic         unused_data;

  // Upper payload bits are intentionally dropped.
  assign unused_data = ^s_in_data[127:32];

  // Ready depends only on the registered count, so a same-cycle pop never
  // opens a slot for a push.
  assign s_in_rdy    = !fifo_full && !rst;
  assign s_out_valid = !fifo_empty;
  assign accept      = s_in_valid && s_in_rdy;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = sum_q + s_in_data[31:0];
    end
  end

  // Checksum field includes the word being pushed.
  assign push_word = format_word(SIG_HI, SIG_MID, sum_d, s_in_data[31:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  pico_fwft_fifo #(
    .WIDTH (STREAM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (push_word),
    .full  (fifo_full),
    .pop   (s_out_rdy),
    .dout  (head_word),
    .empty (fifo_empty)
  );

  assign s_out_data = head_word;

endmodule

// File: tb/tb_pico_stream_loopback.sv
// Self-checking bench for pico_stream_loopback: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_pico_stream_loopback;

  localparam int unsigned DEPTH   = 16;
  localparam logic [31:0] SIG_HI  = 32'h42424242;
  localparam logic [31:0] SIG_MID = 32'hDEADBEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_in_valid;
  logic         s_in_rdy;
  logic [127:0] s_in_data;
  logic         s_out_valid;
  logic         s_out_rdy;
  logic [127:0] s_out_data;

  int checks = 0;
  int errors = 0;

  logic [127:0] mq[$];
  logic [31:0]  msum;

  always #5 clk = ~clk;

  pico_stream_loopback #(
    .DEPTH   (DEPTH),
    .SIG_HI  (SIG_HI),
    .SIG_MID (SIG_MID)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in_valid  (s_in_valid),
    .s_in_rdy    (s_in_rdy),
    .s_in_data   (s_in_data),
    .s_out_valid (s_out_valid),
    .s_out_rdy   (s_out_rdy),
    .s_out_data  (s_out_data)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of formatted words and a running sum.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      msum = 32'h0;
    end else begin
      bit do_pop, do_push;
      do_pop  = s_out_rdy && (mq.size() != 0);
      do_push = s_in_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        msum = msum + s_in_data[31:0];
        mq.push_back({SIG_HI, SIG_MID, msum, s_in_data[31:0]});
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    check("s_in_rdy", {127'b0, s_in_rdy}, {127'b0, (!rst && (mq.size() < DEPTH))});
    check("s_out_valid", {127'b0, s_out_valid}, {127'b0, (mq.size() != 0)});
    if (mq.size() != 0) check("s_out_data", s_out_data, mq[0]);
  end

  function automatic logic [127:0] fmt(input logic [31:0] s, input logic [31:0] d);
    return {SIG_HI, SIG_MID, s, d};
  endfunction

  task automatic push(input logic [31:0] lo);
    s_in_data  = {$urandom, $urandom, $urandom, lo};
    s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [127:0] exp);
    int n = 0;
    while (!s_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid"}, {127'b0, s_out_valid}, 128'h1);
    check(name, s_out_data, exp);
    s_out_rdy = 1'b1;
    @(posedge clk);
    #1;
    s_out_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    s_out_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {127'b0, s_in_rdy}, 128'h0);
    check("rst_valid", {127'b0, s_out_valid}, 128'h0);
    check("rst_data", s_out_data, 128'h0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", {127'b0, s_in_rdy}, 128'h1);

    // Single word, one-cycle latency.
    push(32'h1);
    check("t1_latency", {127'b0, s_out_valid}, 128'h1);
    pop_expect("t1_pop", 128'h42424242_DEADBEEF_00000001_00000001);

    // Two words.
    push(32'h10);
    push(32'h1000);
    pop_expect("t2_pop0", 128'h42424242_DEADBEEF_00000011_00000010);
    pop_expect("t2_pop1", 128'h42424242_DEADBEEF_00001011_00001000);

    // Sum persists across transfers.
    push(32'h1);
    push(32'h10);
    push(32'h1000);
    pop_expect("t3_pop0", 128'h42424242_DEADBEEF_00001012_00000001);
    pop_expect("t3_pop1", 128'h42424242_DEADBEEF_00001022_00000010);
    pop_expect("t3_pop2", 128'h42424242_DEADBEEF_00002022_00001000);

    // Fill to DEPTH with the output stalled.
    for (int i = 0; i < DEPTH; i++) push(32'h1);
    check("t4_full_rdy", {127'b0, s_in_rdy}, 128'h0);
    push(32'hABC);
    for (int k = 1; k <= DEPTH; k++) pop_expect("t4_drain", fmt(32'h2022 + k, 32'h1));
    push(32'h0);
    pop_expect("t4_sum_held", 128'h42424242_DEADBEEF_00002032_00000000);

    // Checksum wrap.
    do_reset();
    push(32'hFFFFFFFF);
    push(32'h2);
    pop_expect("t5_pop0", 128'h42424242_DEADBEEF_FFFFFFFF_FFFFFFFF);
    pop_expect("t5_wrap", 128'h42424242_DEADBEEF_00000001_00000002);

    // Asynchronous reset mid-stream.
    push(32'h7);
    push(32'h8);
    push(32'h9);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", {127'b0, s_out_valid}, 128'h0);
    check("t6_async_rdy", {127'b0, s_in_rdy}, 128'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6_release_rdy", {127'b0, s_in_rdy}, 128'h1);
    check("t6_release_data", s_out_data, 128'h0);
    push(32'h5);
    pop_expect("t6_pop", 128'h42424242_DEADBEEF_00000005_00000005);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_stream_loopback.md
Name: pico_stream_loopback

Overview:
- 128-bit stream loopback endpoint behind the PicoBus host stream channel (stream ID 1).
- Accepts 128-bit words from the host write stream and buffers them in a FIFO.
- Returns each word on the host read stream, in order, tagged with a constant signature and a running checksum.
- Used as the reference target for host-side stream DMA tests.

Parameters:
- DEPTH, 16, FIFO capacity in 128-bit words; power of two, minimum 4.
- SIG_HI, 32'h42424242, constant placed in output bits [127:96].
- SIG_MID, 32'hDEADBEEF, constant placed in output bits [95:64].

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_in_valid  in  1  host write-stream word valid.
- s_in_rdy  out  1  block can accept a word.
- s_in_data  in  128  host write-stream word.
- s_out_valid  out  1  output word available.
- s_out_rdy  in  1  host consumes output word.
- s_out_data  out  128  output word.

Behaviour:
- Input handshake: a word is accepted on a clk edge where s_in_valid && s_in_rdy.
- s_in_rdy = FIFO not full.
- Running sum:
  - 32-bit register sum, reset to 0.
  - On each accepted word, sum_next = sum + s_in_data[31:0], wrapping mod 2^32.
- Word formed at acceptance and pushed into the FIFO: {SIG_HI, SIG_MID, sum_next, s_in_data[31:0]}.
  - The checksum field therefore includes the current word.
  - s_in_data[127:32] is discarded.
- Output:
  - s_out_valid = FIFO not empty.
  - s_out_data = FIFO head (first-word-fall-through); stable while s_out_valid && !s_out_rdy.
  - A pop occurs on a clk edge where s_out_valid && s_out_rdy.
- Latency: a word accepted at edge N is visible on s_out_data with s_out_valid=1 after edge N (one cycle), when the FIFO was empty.
- Full: s_in_rdy=0; s_in_valid is ignored and sum does not change.
- Empty: s_out_valid=0; s_out_data holds the last value (don't-care).
- Simultaneous push and pop:
  - Both occur and the occupancy count is unchanged.
  - When full, a pop in the same cycle does not enable a push; s_in_rdy depends only on the registered count.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally; occupancy is a separate counter of width log2(DEPTH)+1.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count and sum clear to 0.
  - s_out_valid=0 and s_in_rdy=0 while rst is high; s_in_rdy=1 in the first cycle after release.
  - s_out_data resets to 0.
  - FIFO contents are lost.
- Sum persists across stream transfers; only rst clears it.

Decomposition:
- Shared package pico_stream_pkg:
  - STREAM_W=128.
  - Signature constants SIG_HI and SIG_MID.
  - Typedef stream_word_t (logic [127:0]).
- One sub-module: pico_fwft_fifo (parameters WIDTH, DEPTH).
  - Ports: clk, rst, push, din, full, pop, dout, empty.
- Top level contains only the checksum register, word formatting and handshake glue.

Test Plan:
- Reset, then push one word 128'h1; pop it -> 128'h42424242_DEADBEEF_00000001_00000001.
- Push 128'h10 then 128'h1000; pop both -> ..._00000011_00000010, then ..._00001011_00001000.
- Push 1, 0x10, 0x1000 (continuing from the previous test); pop first -> 128'h42424242_DEADBEEF_00001012_00000001.
- Hold s_out_rdy=0 and push DEPTH words:
  - s_in_rdy drops to 0 after the DEPTH-th push.
  - An extra s_in_valid pulse is not accepted and sum is unchanged.
  - Draining returns DEPTH words in order.
- Push 32'hFFFFFFFF then 32'h2 after reset -> checksum fields FFFFFFFF, then 00000001 (wrap).
- Assert rst mid-stream with 3 words queued:
  - s_out_valid=0 immediately (asynchronous).
  - After release, push 128'h5 -> ..._00000005_00000005.
